// File: rtl/fetch_pkg.sv
// Shared bus and pipeline types used by the fetch stage and its neighbours.
`default_nettype none

package common;
   typedef logic [63:0] u64;
   typedef logic [31:0] u32;

   typedef struct packed {
      logic valid;
      u64   addr;
   } ibus_req_t;

   typedef struct packed {
      logic addr_ok;
      logic data_ok;
      u32   data;
   } ibus_resp_t;
endpackage

package pipes;
   import common::*;

   typedef struct packed {
      logic valid;
      u64   pc;
      u32   raw_instr;
      logic instr_misalign;
   } fetch_data_t;

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2,
      S_MIS     = 2'd3
   } fetch_state_e;

   localparam u32 NOP_INSTR = 32'h0000_0013;

   // A freshly loaded PC either starts a bus read or parks in the misaligned state.
   function automatic fetch_state_e entry_state(input logic [1:0] pc_lsb);
      return (pc_lsb != 2'b00) ? S_MIS : S_REQ;
   endfunction
endpackage

`default_nettype wire

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} buffer that catches a returned instruction while decode is stalled.
`default_nettype none

module fetch_skid
   import common::*;
(
   input  logic clk,
   input  logic rst_ni,
   input  logic load_i,
   input  logic clear_i,
   input  u64   pc_i,
   input  u32   instr_i,
   output logic full_o,
   output u64   pc_o,
   output u32   instr_o
);

   logic full_q;
   u64   pc_q;
   u32   instr_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q  <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else if (clear_i) begin
         full_q  <= 1'b0;
      end else if (load_i) begin
         full_q  <= 1'b1;
         pc_q    <= pc_i;
         instr_q <= instr_i;
      end
   end

   assign full_o  = full_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues single outstanding word reads and
// registers fetch_data_t into decode, with stall skid and redirect handling.
`default_nettype none

module fetch
   import common::*;
   import pipes::*;
#(
   parameter u64 RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output ibus_req_t   ireq,
   input  ibus_resp_t  iresp,
   input  logic        stall,
   input  logic        redirect,
   input  u64          redirect_pc,
   output fetch_data_t dataF
);

   fetch_state_e state_q, state_d;
   u64           pc_q, pc_d;
   u64           pend_q, pend_d;
   fetch_data_t  data_q, data_d;

   logic skid_load, skid_clear, skid_full;
   u64   skid_pc;
   u32   skid_instr;
   u64   pc_inc;
   logic unused_addr_ok;

   assign pc_inc         = pc_q + 64'd4;
   assign unused_addr_ok = iresp.addr_ok;

   fetch_skid u_skid (
      .clk     (clk),
      .rst_ni  (reset),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .pc_i    (pc_q),
      .instr_i (iresp.data),
      .full_o  (skid_full),
      .pc_o    (skid_pc),
      .instr_o (skid_instr)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      data_d     = data_q;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      // pc_q still holds the in-flight address while a read is being discarded.
      ireq = '{valid: reset && (state_q == S_REQ || state_q == S_DISCARD), addr: pc_q};

      if (redirect) begin
         data_d.valid = 1'b0;
         skid_clear   = 1'b1;
         case (state_q)
            S_REQ, S_DISCARD: begin
               if (iresp.data_ok) begin
                  pc_d    = redirect_pc;
                  state_d = entry_state(redirect_pc[1:0]);
               end else begin
                  pend_d  = redirect_pc;
                  state_d = S_DISCARD;
               end
            end
            default: begin
               pc_d    = redirect_pc;
               state_d = entry_state(redirect_pc[1:0]);
            end
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (iresp.data_ok) begin
                  pc_d = pc_inc;
                  if (stall) begin
                     skid_load = 1'b1;
                     state_d   = S_HOLD;
                  end else begin
                     data_d  = '{valid: 1'b1, pc: pc_q, raw_instr: iresp.data, instr_misalign: 1'b0};
                     state_d = entry_state(pc_inc[1:0]);
                  end
               end else if (!stall) begin
                  data_d.valid = 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  data_d     = '{valid: skid_full, pc: skid_pc, raw_instr: skid_instr, instr_misalign: 1'b0};
                  skid_clear = 1'b1;
                  state_d    = entry_state(pc_q[1:0]);
               end
            end
            S_DISCARD: begin
               if (iresp.data_ok) begin
                  pc_d    = pend_q;
                  state_d = entry_state(pend_q[1:0]);
               end
            end
            S_MIS: begin
               if (!stall) begin
                  data_d = '{valid: 1'b1, pc: pc_q, raw_instr: NOP_INSTR, instr_misalign: 1'b1};
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
      end
   end

   assign dataF = data_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed vector table, hand-written corner cases
// and randomized traffic against an abstract reference model.
`default_nettype none

module tb_fetch;
   import common::*;
   import pipes::*;

   localparam u64 RESET_PC = 64'h8000_0000;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   u64          redirect_pc;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   fetch_data_t dataF;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      u64 pc;
      u32 ins;
   } ent_t;

   // Reference model: next fetch address, optional read-to-drop with its target,
   // a held instruction list and the expected decode record.
   u64          m_pc;
   u64          m_tgt;
   bit          m_drop;
   ent_t        m_held[$];
   fetch_data_t m_out;

   typedef struct {
      bit st;
      bit rd;
      u64 rpc;
      bit dok;
      bit e_rv;
      u64 e_ra;
      bit e_dv;
      u64 e_dpc;
      bit e_mis;
   } vec_t;

   vec_t tbl[20];

   fetch #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .ireq        (ireq),
      .iresp       (iresp),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .dataF       (dataF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic u32 mem(input u64 a);
      return a[31:0] ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit exp_rv();
      return m_drop || (m_held.size() == 0 && m_pc[1:0] == 2'b00);
   endfunction

   task automatic chk(input string name, input u64 act, input u64 exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = RESET_PC;
      m_tgt  = '0;
      m_drop = 1'b0;
      m_held.delete();
      m_out  = '0;
   endtask

   task automatic model_step(input bit st, input bit rd, input u64 rpc, input bit dok);
      bit rv;
      rv = exp_rv();
      if (rd) begin
         m_out.valid = 1'b0;
         m_held.delete();
         if (rv && !dok) begin
            m_drop = 1'b1;
            m_tgt  = rpc;
         end else begin
            m_drop = 1'b0;
            m_pc   = rpc;
         end
      end else if (m_drop) begin
         if (dok) begin
            m_drop = 1'b0;
            m_pc   = m_tgt;
         end
      end else if (m_held.size() != 0) begin
         if (!st) begin
            m_out = '{1'b1, m_held[0].pc, m_held[0].ins, 1'b0};
            m_held.delete();
         end
      end else if (m_pc[1:0] != 2'b00) begin
         if (!st) m_out = '{1'b1, m_pc, NOP_INSTR, 1'b1};
      end else if (dok) begin
         if (st) m_held.push_back('{m_pc, mem(m_pc)});
         else    m_out = '{1'b1, m_pc, mem(m_pc), 1'b0};
         m_pc = m_pc + 64'd4;
      end else if (!st) begin
         m_out.valid = 1'b0;
      end
   endtask

   task automatic check_model();
      bit rv;
      rv = exp_rv();
      chk("model ireq.valid", 64'(ireq.valid), 64'(rv));
      if (rv) chk("model ireq.addr", ireq.addr, m_pc);
      chk("model dataF.valid", 64'(dataF.valid), 64'(m_out.valid));
      if (m_out.valid) begin
         chk("model dataF.pc", dataF.pc, m_out.pc);
         chk("model dataF.raw_instr", 64'(dataF.raw_instr), 64'(m_out.raw_instr));
         chk("model dataF.misalign", 64'(dataF.instr_misalign), 64'(m_out.instr_misalign));
      end
   endtask

   // Called at a falling edge: drive one cycle of inputs, advance, check at next falling edge.
   task automatic do_cycle(input bit st, input bit rd, input u64 rpc, input bit dok);
      bit d;
      d             = dok && exp_rv();
      stall         = st;
      redirect      = rd;
      redirect_pc   = rpc;
      iresp.data_ok = d;
      iresp.addr_ok = d;
      iresp.data    = mem(ireq.addr);
      model_step(st, rd, rpc, d);
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   initial begin
      tbl[0]  = '{0, 0, 64'h0,           1, 1, 64'h8000_0004, 1, 64'h8000_0000, 0};
      tbl[1]  = '{0, 0, 64'h0,           1, 1, 64'h8000_0008, 1, 64'h8000_0004, 0};
      tbl[2]  = '{1, 0, 64'h0,           1, 0, 64'h0,         1, 64'h8000_0004, 0};
      tbl[3]  = '{1, 0, 64'h0,           1, 0, 64'h0,         1, 64'h8000_0004, 0};
      tbl[4]  = '{1, 0, 64'h0,           1, 0, 64'h0,         1, 64'h8000_0004, 0};
      tbl[5]  = '{0, 0, 64'h0,           0, 1, 64'h8000_000C, 1, 64'h8000_0008, 0};
      tbl[6]  = '{0, 0, 64'h0,           0, 1, 64'h8000_000C, 0, 64'h0,         0};
      tbl[7]  = '{0, 0, 64'h0,           1, 1, 64'h8000_0010, 1, 64'h8000_000C, 0};
      tbl[8]  = '{0, 0, 64'h0,           0, 1, 64'h8000_0010, 0, 64'h0,         0};
      tbl[9]  = '{0, 1, 64'h8000_0100,   0, 1, 64'h8000_0010, 0, 64'h0,         0};
      tbl[10] = '{0, 0, 64'h0,           1, 1, 64'h8000_0100, 0, 64'h0,         0};
      tbl[11] = '{0, 0, 64'h0,           1, 1, 64'h8000_0104, 1, 64'h8000_0100, 0};
      tbl[12] = '{0, 1, 64'h8000_0200,   1, 1, 64'h8000_0200, 0, 64'h0,         0};
      tbl[13] = '{0, 0, 64'h0,           1, 1, 64'h8000_0204, 1, 64'h8000_0200, 0};
      tbl[14] = '{0, 1, 64'h8000_0102,   1, 0, 64'h0,         0, 64'h0,         0};
      tbl[15] = '{0, 0, 64'h0,           0, 0, 64'h0,         1, 64'h8000_0102, 1};
      tbl[16] = '{1, 0, 64'h0,           0, 0, 64'h0,         1, 64'h8000_0102, 1};
      tbl[17] = '{0, 0, 64'h0,           0, 0, 64'h0,         1, 64'h8000_0102, 1};
      tbl[18] = '{0, 1, 64'h8000_0300,   0, 1, 64'h8000_0300, 0, 64'h0,         0};
      tbl[19] = '{0, 0, 64'h0,           1, 1, 64'h8000_0304, 1, 64'h8000_0300, 0};

      reset       = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      iresp       = '0;
      #1 reset    = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset dataF", 64'(dataF.valid), 64'd0);
      chk("reset dataF.pc", dataF.pc, 64'd0);
      chk("reset ireq.valid", 64'(ireq.valid), 64'd0);
      reset = 1'b1;
      #1;
      chk("release ireq.valid", 64'(ireq.valid), 64'd1);
      chk("release ireq.addr", ireq.addr, RESET_PC);

      for (int i = 0; i < 20; i++) begin
         do_cycle(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].dok);
         chk($sformatf("tbl%0d ireq.valid", i), 64'(ireq.valid), 64'(tbl[i].e_rv));
         if (tbl[i].e_rv) chk($sformatf("tbl%0d ireq.addr", i), ireq.addr, tbl[i].e_ra);
         chk($sformatf("tbl%0d dataF.valid", i), 64'(dataF.valid), 64'(tbl[i].e_dv));
         if (tbl[i].e_dv) begin
            chk($sformatf("tbl%0d dataF.pc", i), dataF.pc, tbl[i].e_dpc);
            chk($sformatf("tbl%0d dataF.raw_instr", i), 64'(dataF.raw_instr),
                64'(tbl[i].e_mis ? NOP_INSTR : mem(tbl[i].e_dpc)));
            chk($sformatf("tbl%0d dataF.misalign", i), 64'(dataF.instr_misalign), 64'(tbl[i].e_mis));
         end
      end

      // PC wraps from the top of the address space to zero.
      do_cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      chk("wrap ireq.addr", ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
      do_cycle(1'b0, 1'b0, 64'h0, 1'b1);
      chk("wrap dataF.pc", dataF.pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap next ireq.addr", ireq.addr, 64'h0);

      // Reset asserted while an instruction sits in the skid buffer.
      do_cycle(1'b1, 1'b0, 64'h0, 1'b1);
      chk("hold ireq.valid", 64'(ireq.valid), 64'd0);
      #2 reset = 1'b0;
      #1;
      chk("async reset dataF.valid", 64'(dataF.valid), 64'd0);
      chk("async reset dataF.pc", dataF.pc, 64'd0);
      chk("async reset ireq.valid", 64'(ireq.valid), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      chk("restart ireq.addr", ireq.addr, RESET_PC);
      do_cycle(1'b0, 1'b0, 64'h0, 1'b1);
      chk("restart dataF.pc", dataF.pc, RESET_PC);

      for (int i = 0; i < 600; i++) begin
         bit st;
         bit rd;
         bit dok;
         u64 rpc;
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 11) == 0);
         dok = ($urandom_range(0, 2) != 0);
         rpc = RESET_PC + (64'($urandom_range(0, 255)) << 2);
         if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         do_cycle(st, rd, rpc, dok);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
